// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a byte FIFO feeding an 8N1 serializer (8E1 when
// UART_TX_PARITY_EN is defined). The bit period is latched per frame.
`timescale 1ns/1ps

module uart_tx_buffered #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [7:0]               wr_data_i,
    input  logic [15:0]              baud_i,
    input  logic                     wrerr_clr_i,
    output logic                     tx_o,
    output logic                     busy_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     wrerr_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;

    state_t        state;
    logic [15:0]   period_q;
    logic [15:0]   timer;
    logic [2:0]    bit_idx;
    logic [7:0]    data_q;

    logic          bit_end;
    logic          push;
    logic          pop;
    logic          overflow;
    logic [15:0]   period_in;

    assign bit_end   = (timer == 16'd0);
    assign push      = wr_en_i & ~full_o;
    assign overflow  = wr_en_i & full_o;
    // A new frame may only be taken from idle or at the very end of a stop bit.
    assign pop       = ~empty_o & ((state == IDLE) | ((state == STOP) & bit_end));
    assign period_in = (baud_i == 16'd0) ? 16'd1 : baud_i;

    always_comb begin
        count_nxt = count_o;
        if (push && !pop) begin
            count_nxt = count_o + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count_o - CW'(1);
        end
    end

    // Storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
            empty_o <= 1'b1;
            full_o  <= 1'b0;
            wrerr_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_o <= count_nxt;
            empty_o <= (count_nxt == '0);
            full_o  <= (count_nxt == CW'(DEPTH));
            if (overflow) begin
                wrerr_o <= 1'b1;
            end else if (wrerr_clr_i) begin
                wrerr_o <= 1'b0;
            end
        end
    end

    // Frame sequencer; the bit timer counts down to 0 and reloads on each boundary.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
            period_q <= 16'd1;
            timer    <= 16'd0;
            bit_idx  <= 3'd0;
            data_q   <= 8'd0;
        end else begin
            if (!bit_end) begin
                timer <= timer - 16'd1;
            end
            case (state)
                IDLE: begin
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        tx_o    <= data_q[0];
                        bit_idx <= 3'd0;
                        timer   <= period_q - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= period_q - 16'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx_o  <= ^data_q;
`else
                            state <= STOP;
                            tx_o  <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_o    <= data_q[bit_idx + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        tx_o  <= 1'b1;
                        timer <= period_q - 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end && !pop) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                end
            endcase
            // Loading a frame overrides whatever the state above decided.
            if (pop) begin
                state    <= START;
                tx_o     <= 1'b0;
                busy_o   <= 1'b1;
                data_q   <= mem[rd_ptr];
                period_q <= period_in;
                timer    <= period_in - 16'd1;
                bit_idx  <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: a frame-level model predicts when each
// byte starts and with which period; a line monitor decodes tx and compares.
`timescale 1ns/1ps

module tb_uart_tx_buffered;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic [15:0]   baud;
    logic          wrerr_clr;
    logic          tx_o;
    logic          busy_o;
    logic          empty_o;
    logic          full_o;
    logic [CW-1:0] count_o;
    logic          wrerr_o;

    always #5 clk = ~clk;

    uart_tx_buffered #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .wr_en_i     (wr_en),
        .wr_data_i   (wr_data),
        .baud_i      (baud),
        .wrerr_clr_i (wrerr_clr),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .count_o     (count_o),
        .wrerr_o     (wrerr_o)
    );

    typedef struct {
        logic [7:0] data;
        int         period;
        int         start;
    } frame_t;

    frame_t     exp_q[$];
    logic [7:0] pend[$];
    int         cyc;
    int         frame_end;
    int         checks;
    int         failures;
    int         exp_count;
    logic       exp_busy;
    logic       exp_wrerr;
    logic       live;

    logic       in_frame;
    int         mon_bit;
    int         bi;
    int         cnt;
    frame_t     cur;
    logic       bits [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, req);
        end
    endtask

    // Reference model: bytes queue; a frame occupies NB*period edges from its pop.
    initial begin
        frame_t f;
        logic   was_full;
        cyc = 0; frame_end = 0; live = 1'b0;
        exp_wrerr = 1'b0; exp_busy = 1'b0; exp_count = 0;
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) begin
                pend.delete();
                exp_q.delete();
                frame_end = 0;
                exp_wrerr = 1'b0;
                exp_busy  = 1'b0;
                exp_count = 0;
                live      = 1'b0;
            end else begin
                cyc++;
                was_full = (pend.size() == DEPTH);
                if (pend.size() > 0 && cyc >= frame_end) begin
                    f.data   = pend.pop_front();
                    f.period = (baud == 16'd0) ? 1 : int'(baud);
                    f.start  = cyc;
                    exp_q.push_back(f);
                    frame_end = cyc + NB * f.period;
                end
                if (wr_en && !was_full) pend.push_back(wr_data);
                if (wr_en && was_full) exp_wrerr = 1'b1;
                else if (wrerr_clr)   exp_wrerr = 1'b0;
                exp_count = pend.size();
                exp_busy  = (cyc < frame_end);
                live      = 1'b1;
            end
        end
    end

    // Monitor: status compares each cycle; tx decoded sample by sample.
    initial begin
        in_frame = 1'b0; mon_bit = -1; bi = 0; cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni || !live) begin
                in_frame = 1'b0;
                mon_bit  = -1;
            end else begin
                chk("count", 32'(count_o), 32'(exp_count));
                chk("empty", 32'(empty_o), 32'(exp_count == 0));
                chk("full",  32'(full_o),  32'(exp_count == DEPTH));
                chk("busy",  32'(busy_o),  32'(exp_busy));
                chk("wrerr", 32'(wrerr_o), 32'(exp_wrerr));
                if (!in_frame && tx_o == 1'b0) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_start", 32'(tx_o), 32'd1);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("start_cycle", 32'(cyc), 32'(cur.start));
                        bits[0] = 1'b0;
                        for (int i = 0; i < 8; i++) bits[i+1] = cur.data[i];
                        bits[9]  = ^cur.data;
                        bits[NB-1] = 1'b1;
                        in_frame = 1'b1;
                        bi = 0;
                        cnt = 0;
                    end
                end
                if (in_frame) begin
                    chk($sformatf("tx_byte%02h_bit%0d", cur.data, bi), 32'(tx_o), 32'(bits[bi]));
                    cnt++;
                    if (cnt == cur.period) begin
                        cnt = 0;
                        bi++;
                        if (bi == NB) in_frame = 1'b0;
                    end
                end
                mon_bit = in_frame ? bi : -1;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (!(pend.size() == 0 && cyc >= frame_end && !in_frame) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == limit) begin
            checks++; failures++;
            $display("FAIL drain_timeout pending=%0d frames_left=%0d expected=0", pend.size(), exp_q.size());
        end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_ni = 1'b0; wr_en = 1'b0; wr_data = 8'd0; baud = 16'd4; wrerr_clr = 1'b0;
        checks = 0; failures = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_wrerr", 32'(wrerr_o), 32'd0);
        @(negedge clk); rst_ni = 1'b1;
        @(posedge clk); #1;

        // Single bytes at 4 cycles per bit, including parity-sensitive values.
        push(8'h55);
        drain(200);
        push(8'h07);
        push(8'h03);
        drain(300);

        // Burst into a full FIFO, then overflow; set beats clear on a tie.
        baud = 16'd20;
        for (int i = 0; i < 18; i++) begin
            push(8'(i));
            if (i == 16) chk("full_after_fill", 32'(full_o), 32'd1);
            if (i == 17) chk("wrerr_on_overflow", 32'(wrerr_o), 32'd1);
        end
        wrerr_clr = 1'b1; @(posedge clk); #1; wrerr_clr = 1'b0;
        chk("wrerr_cleared", 32'(wrerr_o), 32'd0);
        wrerr_clr = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        @(posedge clk); #1;
        wrerr_clr = 1'b0; wr_en = 1'b0;
        chk("wrerr_set_wins", 32'(wrerr_o), 32'd1);
        wrerr_clr = 1'b1; @(posedge clk); #1; wrerr_clr = 1'b0;
        drain(5000);

        // Period is latched per frame: change it while the first frame is on the line.
        baud = 16'd4;
        push(8'h3C);
        push(8'hC3);
        repeat (10) begin @(posedge clk); #1; end
        baud = 16'd8;
        drain(400);

        // Zero period behaves as one cycle per bit.
        baud = 16'd0;
        push(8'hA5);
        drain(100);

        // Reset in the middle of data bit 3 with another byte queued.
        baud = 16'd4;
        push(8'h00);
        push(8'hFF);
        n = 0;
        while (mon_bit != 4 && n < 200) begin @(negedge clk); #2; n++; end
        if (n == 200) begin
            checks++; failures++;
            $display("FAIL wait_data_bit3 mon_bit=%0d expected=4", mon_bit);
        end
        rst_ni = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx_o), 32'd1);
        chk("midrst_count", 32'(count_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_empty", 32'(empty_o), 32'd1);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        repeat (60) begin @(posedge clk); #1; end
        chk("midrst_no_residual", 32'(tx_o), 32'd1);

        // Random traffic with changing periods and occasional clears.
        repeat (400) begin
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_data   = 8'($urandom);
            wrerr_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) baud = 16'($urandom_range(0, 6));
            @(posedge clk); #1;
        end
        wr_en = 1'b0; wrerr_clr = 1'b0;
        drain(20000);

        chk("frames_left", 32'(exp_q.size()), 32'd0);
        chk("final_tx_idle", 32'(tx_o), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
